psr_cond_unit: RTL

- Processor status register (PSR) stage directly downstream of the 16-bit ALU.
- Latches the ALU flag outputs (C, L, F, Z, N) under a per-flag write mask and supports LPR/SPR-style full-PSR writes and reads.
- Evaluates 4-bit branch/Scond condition codes against the flags and returns a registered take/not-take decision to the controller.
- Holds a one-deep interrupt shadow of the PSR for entry and exit.

---
 rtl/psr_cond_unit_pkg.sv | 29 ++
 rtl/psr_cond_unit_if.sv | 28 ++
 rtl/psr_cond_unit_cond_eval.sv | 35 +++
 rtl/psr_cond_unit.sv | 80 ++++++++
 4 files changed

// File: rtl/psr_cond_unit_pkg.sv
// PSR bit positions, implemented-bit mask and condition-code encodings
// shared by the PSR stage and the Scond writeback path.
package psr_pkg;
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;
    localparam int PSR_E = 9;

    localparam logic [15:0] PSR_IMPL_MASK = 16'h02E5;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
endpackage

// File: rtl/psr_cond_unit_if.sv
// Controller <-> PSR stage signal bundle; master is the controller/ALU side,
// slave is the PSR stage.
interface psr_cond_unit_if #(parameter int WIDTH = 16);
    logic             alu_c, alu_l, alu_f, alu_z, alu_n;
    logic [4:0]       flag_we;
    logic             psr_we;
    logic [WIDTH-1:0] psr_wdata;
    logic [WIDTH-1:0] psr_q;
    logic [3:0]       cond;
    logic             cond_eval;
    logic             take;
    logic             take_valid;
    logic             irq_enter;
    logic             irq_exit;
    logic             shadow_ovf;

    modport master (
        output alu_c, alu_l, alu_f, alu_z, alu_n, flag_we, psr_we, psr_wdata,
               cond, cond_eval, irq_enter, irq_exit,
        input  psr_q, take, take_valid, shadow_ovf
    );

    modport slave (
        input  alu_c, alu_l, alu_f, alu_z, alu_n, flag_we, psr_we, psr_wdata,
               cond, cond_eval, irq_enter, irq_exit,
        output psr_q, take, take_valid, shadow_ovf
    );
endinterface

// File: rtl/psr_cond_unit_cond_eval.sv
// Combinational 4-bit condition-code evaluator over the C/L/F/Z/N flags.
module cond_eval_logic
    import psr_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       c,
    input  logic       l,
    input  logic       f,
    input  logic       z,
    input  logic       n,
    output logic       result
);
    always_comb begin
        result = 1'b0;
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_HI: result = l;
            COND_LS: result = ~l;
            COND_GT: result = n;
            COND_LE: result = ~n;
            COND_FS: result = f;
            COND_FC: result = ~f;
            COND_LO: result = ~l & ~z;
            COND_HS: result = l | z;
            COND_LT: result = ~n & ~z;
            COND_GE: result = n | z;
            COND_UC: result = 1'b1;
            COND_NV: result = 1'b0;
            default: result = 1'b0;
        endcase
    end
endmodule

// File: rtl/psr_cond_unit.sv
// PSR stage: masked flag capture, LPR writes, one-deep interrupt shadow and
// registered condition evaluation. Optional PSR_FLAG_BYPASS_EN evaluates on next-state flags.
module psr_cond_unit
    import psr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    psr_cond_unit_if.slave    bus
);
    localparam logic [WIDTH-1:0] IMPL_MASK = WIDTH'(PSR_IMPL_MASK);

    logic [WIDTH-1:0] psr_r, shadow_r, psr_pre, psr_nxt, flag_src;
    logic             shadow_valid, ovf_r, take_r, take_valid_r, cond_res;
    logic             exit_ok;

    assign exit_ok = bus.irq_exit & ~bus.irq_enter;

    always_comb begin
        psr_pre = psr_r;
        if (bus.psr_we) begin
            psr_pre = bus.psr_wdata & IMPL_MASK;
        end else if (exit_ok) begin
            psr_pre = shadow_r;
        end else begin
            if (bus.flag_we[0]) psr_pre[PSR_C] = bus.alu_c;
            if (bus.flag_we[1]) psr_pre[PSR_L] = bus.alu_l;
            if (bus.flag_we[2]) psr_pre[PSR_F] = bus.alu_f;
            if (bus.flag_we[3]) psr_pre[PSR_Z] = bus.alu_z;
            if (bus.flag_we[4]) psr_pre[PSR_N] = bus.alu_n;
        end
        psr_nxt = psr_pre;
        if (bus.irq_enter) psr_nxt[PSR_E] = 1'b0;
    end

`ifdef PSR_FLAG_BYPASS_EN
    assign flag_src = psr_pre;
`else
    assign flag_src = psr_r;
`endif

    cond_eval_logic u_cond (
        .cond   (bus.cond),
        .c      (flag_src[PSR_C]),
        .l      (flag_src[PSR_L]),
        .f      (flag_src[PSR_F]),
        .z      (flag_src[PSR_Z]),
        .n      (flag_src[PSR_N]),
        .result (cond_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_r        <= '0;
            shadow_r     <= '0;
            shadow_valid <= 1'b0;
            ovf_r        <= 1'b0;
            take_r       <= 1'b0;
            take_valid_r <= 1'b0;
        end else begin
            psr_r        <= psr_nxt;
            take_valid_r <= bus.cond_eval;
            if (bus.cond_eval) take_r <= cond_res;
            // Shadow captures the pre-E-clear value so the same-cycle flag update survives exit.
            if (bus.irq_enter) begin
                shadow_r     <= psr_pre;
                shadow_valid <= 1'b1;
                if (shadow_valid) ovf_r <= 1'b1;
            end else if (exit_ok) begin
                shadow_valid <= 1'b0;
            end
        end
    end

    assign bus.psr_q      = psr_r;
    assign bus.take       = take_r;
    assign bus.take_valid = take_valid_r;
    assign bus.shadow_ovf = ovf_r;
endmodule
